ff_deser_rx: RTL and testbench
==============================

// Module: ff_deser_rx
// PURPOSE
//   Framed serial receiver built from enable/clear flops. It is the receive end of the
//   single-bit d/en/clr serial link that our flop-level blocks drive. It samples d on
//   clock edges where en is high, detects a start bit and shifts in WIDTH data bits
//   MSB-first. It then checks the stop bit and presents the parallel word with a 1-cycle
//   valid pulse, or a frame_err pulse if the stop bit is bad.
// PARAMETERS
//   WIDTH   8   data bits per frame; legal range 2..32
//   CNT_W   5   bit counter width; must satisfy 2**CNT_W >= WIDTH
// PORTS
//   clk        in   1      single clock; all state updates on posedge clk
//   clr        in   1      reset; synchronous, active-high; overrides every other input
//   en         in   1      bit strobe; d is sampled only on edges where en=1
//   d          in   1      serial data bit
//   q          out  WIDTH  last correctly framed word; holds until the next good frame
//   valid      out  1      1-cycle pulse; q was updated on this edge
//   frame_err  out  1      1-cycle pulse; stop bit sampled as 1, frame discarded
//   busy       out  1      high while in SHIFT or STOP
// BEHAVIOUR
//   Reset
//   - On an edge with clr=1: state=IDLE, cnt=0, sreg=0, q=0, valid=0, frame_err=0, busy=0.
//   - clr mid-frame aborts the frame. No valid or frame_err is raised for it. q is cleared to 0.
//   Strobe
//   - Edges with en=0 hold state, cnt and sreg unchanged. valid and frame_err still drop to 0.
//   - A frame may be stretched by any number of en=0 gaps between bits.
//   FSM (registered; the state advances only on en=1 edges)
//   - IDLE:  d=1 -> SHIFT with cnt=0.  d=0 -> stay IDLE (line idles low).
//   - SHIFT: sreg <= {sreg[WIDTH-2:0], d}, cnt <= cnt+1.
//            When cnt==WIDTH-1 this sample is the last data bit -> STOP.
//   - STOP:  d=0 -> q <= sreg, valid <= 1.  d=1 -> frame_err <= 1, q unchanged.
//            Either way -> IDLE, cnt=0.
//   Outputs
//   - busy = (state != IDLE). It is a registered state decode, so it is high from the
//     edge after the start bit through the edge that samples the stop bit.
//   - Latency: valid and frame_err rise on the same edge that samples the stop bit, and
//     are high for exactly one cycle.
//   - valid and frame_err are never high together.
//   - q changes only on an edge that also raises valid, or on clr.
//   Frame format and boundaries
//   - One frame = 1 start bit + WIDTH data bits + 1 stop bit = WIDTH+2 strobes.
//   - Back-to-back frames: a start bit may arrive on the strobe immediately after the stop
//     strobe (no idle gap required). It is accepted from IDLE normally.
//   - After frame_err the FSM returns to IDLE. A stop bit of 1 is NOT reinterpreted as a
//     new start bit; the next start bit is sampled on a later strobe.
//   - Data value 0 and all-ones are legal. No parity.
//   - cnt never exceeds WIDTH-1. No wrap-around is reachable.
//   - X on d while en=0 has no effect. X on en or clr is a bench error.
// TESTING  (WIDTH=8, en high every cycle unless stated)
//   1. clr=1 for 2 edges, then clr=0, d=0 for 5 edges -> q=0x00, valid=0, frame_err=0, busy=0 throughout.
//   2. Bits 1,1,0,1,0,0,1,0,1,0 (start, 0xA5 MSB-first, stop) -> valid pulse on the 10th edge,
//      q=0xA5, busy high for edges 2..10.
//   3. Same frame but stop bit=1 -> frame_err one cycle on the 10th edge, valid=0, q keeps its prior value.
//   4. en toggled 1/0 every cycle while sending frame 0x3C -> valid after 10 strobes (19 edges), q=0x3C.
//   5. Two frames 0xFF then 0x00 with no gap -> two valid pulses 10 edges apart, q=0xFF then q=0x00.
//   6. clr=1 on the edge after the 4th data bit of frame 0x81 -> no valid/frame_err, q=0, busy=0;
//      a full frame 0x81 sent next -> q=0x81.

Source files
------------

// File: rtl/ff_deser_rx.sv
// Framed serial receiver for the d/en/clr flop-level link.
// Samples d on en-strobed edges: start bit (1), WIDTH data bits MSB-first, stop bit (0).
// A good frame updates q with a one-cycle valid pulse. A bad stop bit gives a frame_err pulse.
module ff_deser_rx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             frame_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StStop
    } state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    // Next-state logic: everything holds on en=0 edges, except the pulses, which drop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        q_d     = q_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (en) begin
            unique case (state_q)
                StIdle: begin
                    // The line idles low, so a sampled 1 is the start bit.
                    if (d) begin
                        state_d = StShift;
                        cnt_d   = '0;
                    end
                end
                StShift: begin
                    sreg_d = {sreg_q[WIDTH-2:0], d};
                    if (cnt_q == CntLast) begin
                        // Last data bit. Return cnt to 0 so it never passes WIDTH-1.
                        state_d = StStop;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StStop: begin
                    if (!d) begin
                        q_d     = sreg_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    // A stop bit of 1 goes back to idle. It does not count as a new start bit.
                    state_d = StIdle;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State register. The synchronous clr overrides every other input.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sreg_q  <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // The outputs are the registers, or a decode of the registered state.
    always_comb begin
        q         = q_q;
        valid     = valid_q;
        frame_err = err_q;
        busy      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_ff_deser_rx.sv
// Directed bench for ff_deser_rx (WIDTH=8): vector table plus multi-cycle sequences.
module tb_ff_deser_rx;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       en  = 1'b0;
    logic       d   = 1'b0;
    logic [7:0] q;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       clr;
        logic       en;
        logic       d;
        logic [7:0] eq;
        logic       ev;
        logic       ee;
        logic       eb;
    } vec_t;

    vec_t vecs[$];

    ff_deser_rx #(.WIDTH(8), .CNT_W(5)) dut (
        .clk       (clk),
        .clr       (clr),
        .en        (en),
        .d         (d),
        .q         (q),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Drive inputs at negedge, then sample outputs 1 time unit after the posedge.
    task automatic step(input logic c, input logic e, input logic b);
        @(negedge clk);
        clr = c;
        en  = e;
        d   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] eq, input logic ev,
                             input logic ee, input logic eb);
        check({tag, " q"}, 32'(q), 32'(eq));
        check({tag, " valid"}, 32'(valid), 32'(ev));
        check({tag, " frame_err"}, 32'(frame_err), 32'(ee));
        check({tag, " busy"}, 32'(busy), 32'(eb));
    endtask

    task automatic add(input logic c, input logic e, input logic b, input logic [7:0] eq,
                       input logic ev, input logic ee, input logic eb);
        vec_t v;
        v.clr = c;
        v.en  = e;
        v.d   = b;
        v.eq  = eq;
        v.ev  = ev;
        v.ee  = ee;
        v.eb  = eb;
        vecs.push_back(v);
    endtask

    // Send start + data MSB-first + stop. If gapped, put an en=0 edge between strobes,
    // driving the inverted bit on d so that an ignored sample shows up if it is taken.
    task automatic send_frame(input logic [7:0] data, input logic stop, input logic gapped);
        logic [9:0] bits;
        bits = {1'b1, data, stop};
        for (int k = 9; k >= 0; k--) begin
            if (gapped && k != 9) step(1'b0, 1'b0, ~bits[k]);
            step(1'b0, 1'b1, bits[k]);
        end
    endtask

    initial begin
        // Test 1: reset, then idle low.
        add(1, 1, 0, 8'h00, 0, 0, 0);
        add(1, 1, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 0, 8'h00, 0, 0, 0);
        // Test 2: start, 0xA5 MSB-first, stop=0.
        add(0, 1, 1, 8'h00, 0, 0, 1);
        add(0, 1, 1, 8'h00, 0, 0, 1);
        add(0, 1, 0, 8'h00, 0, 0, 1);
        add(0, 1, 1, 8'h00, 0, 0, 1);
        add(0, 1, 0, 8'h00, 0, 0, 1);
        add(0, 1, 0, 8'h00, 0, 0, 1);
        add(0, 1, 1, 8'h00, 0, 0, 1);
        add(0, 1, 0, 8'h00, 0, 0, 1);
        add(0, 1, 1, 8'h00, 0, 0, 1);
        add(0, 1, 0, 8'hA5, 1, 0, 0);
        add(0, 1, 0, 8'hA5, 0, 0, 0);
        // Test 3: same data, stop=1 -> frame_err, q keeps 0xA5.
        add(0, 1, 1, 8'hA5, 0, 0, 1);
        add(0, 1, 1, 8'hA5, 0, 0, 1);
        add(0, 1, 0, 8'hA5, 0, 0, 1);
        add(0, 1, 1, 8'hA5, 0, 0, 1);
        add(0, 1, 0, 8'hA5, 0, 0, 1);
        add(0, 1, 0, 8'hA5, 0, 0, 1);
        add(0, 1, 1, 8'hA5, 0, 0, 1);
        add(0, 1, 0, 8'hA5, 0, 0, 1);
        add(0, 1, 1, 8'hA5, 0, 0, 1);
        add(0, 1, 1, 8'hA5, 0, 1, 0);
        add(0, 1, 0, 8'hA5, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].clr, vecs[i].en, vecs[i].d);
            check_all($sformatf("vec%0d", i), vecs[i].eq, vecs[i].ev, vecs[i].ee, vecs[i].eb);
        end

        // Test 4: en toggling, frame 0x3C -> valid after 19 edges.
        send_frame(8'h3C, 1'b0, 1'b1);
        check_all("gapped stop", 8'h3C, 1, 0, 0);
        step(1'b0, 1'b0, 1'b1);
        check_all("gapped after", 8'h3C, 0, 0, 0);

        // Test 5: 0xFF then 0x00 back-to-back.
        send_frame(8'hFF, 1'b0, 1'b0);
        check_all("b2b first", 8'hFF, 1, 0, 0);
        step(1'b0, 1'b1, 1'b1);
        check_all("b2b start2", 8'hFF, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_all("b2b second", 8'h00, 1, 0, 0);

        // Test 6: make q nonzero, abort 0x81 with clr after 4 data bits, then resend.
        send_frame(8'h5A, 1'b0, 1'b0);
        check_all("pre abort", 8'h5A, 1, 0, 0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_all("mid frame", 8'h5A, 0, 0, 1);
        step(1'b1, 1'b1, 1'b0);
        check_all("abort clr", 8'h00, 0, 0, 0);
        step(1'b0, 1'b1, 1'b0);
        check_all("abort idle", 8'h00, 0, 0, 0);
        send_frame(8'h81, 1'b0, 1'b0);
        check_all("resend", 8'h81, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
